// File: rtl/handshake_sink_check.sv
// Valid/ready sink that counts accepted tokens and checks each one against EXPECTED.
// Optional macro HANDSHAKE_SINK_STALL_EN inserts STALL_CYCLES of back-pressure after each non-final accept.
module handshake_sink_check #(
  parameter int DATA_WIDTH    = 32,
  parameter     EXPECTED      = 0,
  parameter int EXPECT_TOKENS = 16,
  parameter int CNT_WIDTH     = 16,
  parameter int STALL_CYCLES  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic [CNT_WIDTH-1:0]  tok_count,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] first_bad,
  output logic                  done
);

  localparam logic [DATA_WIDTH-1:0] EXP_VAL  = DATA_WIDTH'(EXPECTED);
  localparam logic [CNT_WIDTH-1:0]  LAST_TOK = CNT_WIDTH'(EXPECT_TOKENS - 1);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = {CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
`ifdef HANDSHAKE_SINK_STALL_EN
    S_STALL = 2'd1,
`endif
    S_DONE  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  ins_ready_q, ins_ready_d;
  logic [CNT_WIDTH-1:0]  tok_count_q, tok_count_d;
  logic [CNT_WIDTH-1:0]  err_count_q, err_count_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] first_bad_q, first_bad_d;
  logic                  done_q, done_d;
  logic                  accept;
  logic                  mismatch;

`ifdef HANDSHAKE_SINK_STALL_EN
  logic [7:0]            stall_cnt_q, stall_cnt_d;
`else
  localparam int unused_stall_cycles = STALL_CYCLES;
`endif

  // ready is only ever high in RUN, so accepts cannot happen in STALL or DONE
  assign accept   = ins_valid && ins_ready_q;
  assign mismatch = accept && (ins != EXP_VAL);

  always_comb begin
    // NOTE: every _d takes its hold value first so no path through this block infers a latch.
    state_d     = state_q;
    ins_ready_d = ins_ready_q;
    tok_count_d = tok_count_q;
    err_count_d = err_count_q;
    err_d       = err_q;
    first_bad_d = first_bad_q;
    done_d      = done_q;
`ifdef HANDSHAKE_SINK_STALL_EN
    stall_cnt_d = stall_cnt_q;
`endif

    if (accept && (tok_count_q != CNT_MAX)) tok_count_d = tok_count_q + CNT_WIDTH'(1);

    if (mismatch) begin
      if (err_count_q != CNT_MAX) err_count_d = err_count_q + CNT_WIDTH'(1);
      // first_bad is frozen once err is set
      if (!err_q) begin
        err_d       = 1'b1;
        first_bad_d = ins;
      end
    end

    case (state_q)
      S_RUN: begin
        ins_ready_d = 1'b1;
        if (accept) begin
          if (tok_count_q == LAST_TOK) begin
            state_d     = S_DONE;
            ins_ready_d = 1'b0;
            done_d      = 1'b1;
          end
`ifdef HANDSHAKE_SINK_STALL_EN
          else begin
            state_d     = S_STALL;
            ins_ready_d = 1'b0;
            stall_cnt_d = 8'(STALL_CYCLES);
          end
`endif
        end
      end
`ifdef HANDSHAKE_SINK_STALL_EN
      S_STALL: begin
        ins_ready_d = 1'b0;
        stall_cnt_d = stall_cnt_q - 8'd1;
        if (stall_cnt_q == 8'd1) begin
          state_d     = S_RUN;
          ins_ready_d = 1'b1;
        end
      end
`endif
      S_DONE: begin
        ins_ready_d = 1'b0;
        done_d      = 1'b1;
      end
      default: begin
        state_d     = S_RUN;
        ins_ready_d = 1'b0;
      end
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_RUN;
      ins_ready_q <= 1'b0;
      tok_count_q <= '0;
      err_count_q <= '0;
      err_q       <= 1'b0;
      first_bad_q <= '0;
      done_q      <= 1'b0;
`ifdef HANDSHAKE_SINK_STALL_EN
      stall_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ins_ready_q <= ins_ready_d;
      tok_count_q <= tok_count_d;
      err_count_q <= err_count_d;
      err_q       <= err_d;
      first_bad_q <= first_bad_d;
      done_q      <= done_d;
`ifdef HANDSHAKE_SINK_STALL_EN
      stall_cnt_q <= stall_cnt_d;
`endif
    end
  end

  assign ins_ready = ins_ready_q;
  assign tok_count = tok_count_q;
  assign err_count = err_count_q;
  assign err       = err_q;
  assign first_bad = first_bad_q;
  assign done      = done_q;

endmodule
